input_conditioner: RTL and testbench

- Upstream front-end for the Mealy `state_machine`.
- Takes a raw, asynchronous, possibly bouncing 1-bit signal and synchronises it to `clk_i`, then debounces it.
- Produces a clean level `in_o` that drives the FSM's `in_i` directly.
- Also produces single-cycle rise/fall event pulses for logging or interrupt use.

---
 rtl/input_conditioner.sv | 130 +++++++++++++
 tb/tb_input_conditioner.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Synchronises a raw asynchronous pin, debounces it into a clean level, and emits edge pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges. No backpressure; en_i=0 freezes the level and drops pending changes.
module input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic raw_i,
   input  logic en_i,
   output logic in_o,
   output logic rise_o,
   output logic fall_o,
   output logic busy_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      STABLE_LO,
      PEND_HI,
      STABLE_HI,
      PEND_LO
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   state_t                 state;
   state_t                 state_nxt;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_nxt;
   logic                   rise_q;
   logic                   rise_nxt;
   logic                   fall_q;
   logic                   fall_nxt;

   // Synchroniser keeps running while disabled so re-enable sees a current level.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state  <= STABLE_LO;
         cnt    <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         rise_q <= rise_nxt;
         fall_q <= fall_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         STABLE_LO: begin
            cnt_nxt = '0;
            if (en_i && sync) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt = STABLE_HI;
                  rise_nxt  = 1'b1;
               end else begin
                  state_nxt = PEND_HI;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end
         PEND_HI: begin
            if (!en_i || !sync) begin
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_HI;
               cnt_nxt   = '0;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         STABLE_HI: begin
            cnt_nxt = '0;
            if (en_i && !sync) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt = STABLE_LO;
                  fall_nxt  = 1'b1;
               end else begin
                  state_nxt = PEND_LO;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end
         PEND_LO: begin
            if (!en_i || sync) begin
               state_nxt = STABLE_HI;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign in_o   = (state == STABLE_HI) || (state == PEND_LO);
   assign busy_o = (state == PEND_HI) || (state == PEND_LO);
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: default instance plus a SYNC_STAGES=3, DEBOUNCE_CYCLES=1 instance.
// Output vectors are {in, rise, fall, busy}.
module tb_input_conditioner;

   localparam logic [3:0] Z  = 4'b0000;
   localparam logic [3:0] B  = 4'b0001;
   localparam logic [3:0] H  = 4'b1000;
   localparam logic [3:0] HB = 4'b1001;
   localparam logic [3:0] R  = 4'b1100;
   localparam logic [3:0] F  = 4'b0010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b0;
   logic en      = 1'b0;
   logic raw     = 1'b0;
   logic raw6    = 1'b0;

   logic in_a, rise_a, fall_a, busy_a;
   logic in_b, rise_b, fall_b, busy_b;

   typedef struct {
      string      tag;
      logic [3:0] a;
      logic [3:0] b;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic       t3_raw [16];
   logic [3:0] t3_exp [16];

   input_conditioner dut_a (
      .clk_i   (clk),
      .reset_i (reset_n),
      .raw_i   (raw),
      .en_i    (en),
      .in_o    (in_a),
      .rise_o  (rise_a),
      .fall_o  (fall_a),
      .busy_o  (busy_a)
   );

   input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_b (
      .clk_i   (clk),
      .reset_i (reset_n),
      .raw_i   (raw6),
      .en_i    (en),
      .in_o    (in_b),
      .rise_o  (rise_b),
      .fall_o  (fall_b),
      .busy_o  (busy_b)
   );

   // Drive one cycle of inputs, queue the expected outputs for that edge, then check them.
   task automatic cyc(input logic r_n, input logic e, input logic r, input logic r6,
                      input logic [3:0] ea, input logic [3:0] eb, input string tag);
      exp_t       x;
      logic [3:0] oa;
      logic [3:0] ob;
      reset_n = r_n;
      en      = e;
      raw     = r;
      raw6    = r6;
      x.tag = tag;
      x.a   = ea;
      x.b   = eb;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x  = sb.pop_front();
      oa = {in_a, rise_a, fall_a, busy_a};
      ob = {in_b, rise_b, fall_b, busy_b};
      n_tests++;
      assert (oa === x.a) else begin
         n_fail++;
         $error("FAIL %s dut_a: observed %b expected %b", x.tag, oa, x.a);
      end
      n_tests++;
      assert (ob === x.b) else begin
         n_fail++;
         $error("FAIL %s dut_b: observed %b expected %b", x.tag, ob, x.b);
      end
   endtask

   initial begin
      t3_raw = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      t3_exp = '{Z, Z, B, Z, B, B, Z, B, B, B, R, H, H, H, H, H};

      // Reset overrides active inputs
      repeat (5) cyc(1'b0, 1'b1, 1'b1, 1'b1, Z, Z, "reset");
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, Z, "idle");

      // Clean rising step
      repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, Z, Z, "t1_sync");
      repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, B, Z, "t1_busy");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, R, Z, "t1_rise");
      repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, H, Z, "t1_hold");
      // Clean falling step
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, H, Z, "t1f_sync");
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, HB, Z, "t1f_busy");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, F, Z, "t1f_fall");
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, Z, "t1f_lo");

      // Glitch rejection: three cycles high
      repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, Z, Z, "t2_sync");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, B, Z, "t2_busy");
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, B, Z, "t2_busy");
      repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, Z, "t2_reject");

      // Bounce then settle
      for (int i = 0; i < 16; i++)
         cyc(1'b1, 1'b1, t3_raw[i], 1'b0, t3_exp[i], Z, "t3_bounce");
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, H, Z, "t3f_sync");
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, HB, Z, "t3f_busy");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, F, Z, "t3f_fall");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, Z, "t3f_lo");

      // Reset while pending with cnt=2
      repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, Z, Z, "t4_sync");
      repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, B, Z, "t4_pend");
      cyc(1'b0, 1'b1, 1'b1, 1'b0, Z, Z, "t4_reset");
      repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, Z, Z, "t4_resync");
      repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, B, Z, "t4_busy");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, R, Z, "t4_rise");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, H, Z, "t4_hold");
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, H, Z, "t4f_sync");
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, HB, Z, "t4f_busy");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, F, Z, "t4f_fall");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, Z, "t4f_lo");

      // Enable gating
      cyc(1'b1, 1'b0, 1'b0, 1'b0, Z, Z, "t5_off");
      repeat (8) cyc(1'b1, 1'b0, 1'b1, 1'b0, Z, Z, "t5_frozen");
      repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, B, Z, "t5_busy");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, R, Z, "t5_rise");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, H, Z, "t5_hold");
      // Dropping enable discards a pending fall; re-enable needs a full count
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, H, Z, "t5f_sync");
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, HB, Z, "t5f_pend");
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, H, Z, "t5f_discard");
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, HB, Z, "t5f_restart");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, F, Z, "t5f_fall");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, Z, "t5f_lo");

      // Three-stage sync, single-cycle debounce
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1, Z, Z, "t6_sync");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, Z, R, "t6_rise");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, Z, H, "t6_hold");
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, H, "t6f_sync");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, F, "t6f_fall");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, Z, "t6f_lo");
      // One-cycle pulse passes straight through with DEBOUNCE_CYCLES=1
      cyc(1'b1, 1'b1, 1'b0, 1'b1, Z, Z, "t6g_sync");
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, Z, "t6g_sync");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, R, "t6g_rise");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, F, "t6g_fall");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, Z, Z, "t6g_lo");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
